// File: rtl/dsm_interp_pkg.sv
// dsm_interp_pkg: shared defaults and FSM encoding for the dsm_interp upsampler.
//   DATA_W_DEF       sample / vin width (shared with dsm_top)
//   RATIO_LOG2_DEF   log2 of the interpolation ratio (shared with dsm_top)
//   FIFO_DEPTH_DEF   input buffer entries
//   interp_state_e   StIdle = 1'b0, StRun = 1'b1
package dsm_interp_pkg;

    localparam int unsigned DATA_W_DEF     = 15;
    localparam int unsigned RATIO_LOG2_DEF = 3;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } interp_state_e;

endpackage

// File: rtl/dsm_interp_fifo.sv
// dsm_interp_fifo: synchronous FIFO with a registered head entry.
//   clock  in   rising-edge clock
//   reset  in   asynchronous, active-high; empties the FIFO
//   push   in   write din when not full
//   din    in   WIDTH data in
//   pop    in   consume the head entry when not empty
//   dout   out  WIDTH registered head entry
//   full   out  DEPTH entries held (head included)
//   empty  out  no head entry available
module dsm_interp_fifo
    import dsm_interp_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W_DEF,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;   // entries in mem, head excluded
    logic             head_valid_q, head_valid_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic [CNT_W-1:0] total;
    logic             do_push;
    logic             do_pop;
    logic             refill;

    // Capacity counts the head register, so in_ready tracks real storage.
    assign total   = count_q + CNT_W'(head_valid_q);
    assign full    = (total == CNT_W'(DEPTH));
    assign empty   = !head_valid_q;
    assign dout    = dout_q;
    assign do_push = push && !full;
    assign do_pop  = pop && head_valid_q;
    // Head reloads from mem whenever it is free or being consumed.
    assign refill  = (!head_valid_q || do_pop) && (count_q != '0);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        head_valid_d = head_valid_q;
        dout_d       = dout_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_d + CNT_W'(1);
        end
        if (refill) begin
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            count_d      = count_d - CNT_W'(1);
            head_valid_d = 1'b1;
            dout_d       = mem[rd_ptr_q];
        end else if (do_pop) begin
            head_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            dout_q       <= dout_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/dsm_interp.sv
// dsm_interp: linear-interpolation upsampler feeding dsm_top.vin.
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-high; clears all state
//   in_data    in   DATA_W signed input sample
//   in_valid   in   in_data valid
//   in_ready   out  FIFO not full; transfer on in_valid & in_ready
//   vin        out  DATA_W signed interpolated sample, straight slice of acc
//   underflow  out  one-cycle pulse after a segment ended with the FIFO empty
module dsm_interp
    import dsm_interp_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned RATIO_LOG2 = RATIO_LOG2_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] vin,
    output logic              underflow
);

    localparam int unsigned ACC_W   = DATA_W + RATIO_LOG2;
    localparam int unsigned DELTA_W = DATA_W + 1;
    localparam logic [RATIO_LOG2-1:0] PHASE_LAST = {RATIO_LOG2{1'b1}};

    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    dsm_interp_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (in_valid),
        .din   (in_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready = !fifo_full;

    interp_state_e            state_q, state_d;
    logic [DATA_W-1:0]        prev_q, prev_d;
    logic [DATA_W-1:0]        cur_q, cur_d;
    logic signed [DELTA_W-1:0] delta_q, delta_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [RATIO_LOG2-1:0]    phase_q, phase_d;
    logic                     underflow_q, underflow_d;

    logic signed [ACC_W-1:0]  cur_scaled;
    logic signed [ACC_W-1:0]  delta_ext;
    logic signed [DELTA_W-1:0] delta_new;

    // A segment always starts from the old cur, so the new acc base is cur*R.
    assign cur_scaled = {cur_q, {RATIO_LOG2{1'b0}}};
    assign delta_ext  = ACC_W'(delta_q);
    // Exact DATA_W+1 difference between the incoming sample and the old cur.
    assign delta_new  = {fifo_dout[DATA_W-1], fifo_dout} - {cur_q[DATA_W-1], cur_q};

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        delta_d     = delta_q;
        acc_d       = acc_q;
        phase_d     = phase_q;
        underflow_d = 1'b0;
        fifo_pop    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    prev_d   = cur_q;
                    cur_d    = fifo_dout;
                    delta_d  = delta_new;
                    acc_d    = cur_scaled;
                    phase_d  = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (phase_q != PHASE_LAST) begin
                    acc_d   = acc_q + delta_ext;
                    phase_d = phase_q + RATIO_LOG2'(1);
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    prev_d   = cur_q;
                    cur_d    = fifo_dout;
                    delta_d  = delta_new;
                    acc_d    = cur_scaled;
                    phase_d  = '0;
                end else begin
                    // Starved: hold flat at cur and flag it.
                    prev_d      = cur_q;
                    delta_d     = '0;
                    acc_d       = cur_scaled;
                    phase_d     = '0;
                    underflow_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            prev_q      <= '0;
            cur_q       <= '0;
            delta_q     <= '0;
            acc_q       <= '0;
            phase_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            delta_q     <= delta_d;
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            underflow_q <= underflow_d;
        end
    end

    assign vin       = acc_q[ACC_W-1:RATIO_LOG2];
    assign underflow = underflow_q;

endmodule
